// File: rtl/acc_skew_scheduler_if.sv
// Bundle between the accumulator FIFOs, the skew scheduler and the
// accumulator array. The slave modport is the scheduler's view. The master
// modport is the view of the block that drives the FIFO heads and the
// tile commands.
interface acc_skew_scheduler_if #(
  parameter int NUM_ROWS = 4,
  parameter int LANE_W   = 16,
  parameter int LEN_W    = 12,
  parameter int STALL_W  = 16
);

  // Tile command
  logic                             start;
  logic                             abort;
  logic [LEN_W-1:0]                 tile_len;

  // FWFT FIFO side
  logic [NUM_ROWS-1:0][LANE_W-1:0]  fifo_data;
  logic [NUM_ROWS-1:0]              fifo_empty;
  logic [NUM_ROWS-1:0]              fifo_pop;

  // Accumulator side
  logic [NUM_ROWS-1:0][LANE_W-1:0]  acc_in;
  logic [NUM_ROWS-1:0]              acc_valid;

  // Status
  logic                             busy;
  logic                             done;
  logic [STALL_W-1:0]               stall_cycles;

  modport master (
    output start, abort, tile_len, fifo_data, fifo_empty,
    input  fifo_pop, acc_in, acc_valid, busy, done, stall_cycles
  );

  modport slave (
    input  start, abort, tile_len, fifo_data, fifo_empty,
    output fifo_pop, acc_in, acc_valid, busy, done, stall_cycles
  );

endinterface

// File: rtl/acc_skew_scheduler.sv
// Skewed (diagonal) wavefront sequencer between the per-row accumulator
// FIFOs and the accumulator array. Row i starts popping i cycles after
// row 0, and each row pops exactly tile_len beats. Any active row whose
// FIFO is empty freezes the entire wavefront, so the diagonal skew never
// breaks. Popped heads reach the accumulator one cycle later, through a
// single register stage.
module acc_skew_scheduler #(
  parameter int NUM_ROWS = 4,
  parameter int LANE_W   = 16,
  parameter int LEN_W    = 12,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  acc_skew_scheduler_if.slave bus
);

  // Wavefront counter is one bit wider than tile_len, so that
  // len + NUM_ROWS - 2 always fits (NUM_ROWS <= 2**LEN_W).
  localparam int T_W = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                           state;
  state_t                           state_nxt;

  logic [T_W-1:0]                   t_q;
  logic [LEN_W-1:0]                 len_q;
  logic [STALL_W-1:0]               stall_cnt;
  logic [T_W-1:0]                   t_last;

  logic [NUM_ROWS-1:0]              active;
  logic [NUM_ROWS-1:0]              pop;
  logic                             stall;
  logic                             final_beat;
  logic                             accept;
  logic                             busy_c;
  logic                             done_c;

  logic [NUM_ROWS-1:0][LANE_W-1:0]  acc_data_p1;
  logic [NUM_ROWS-1:0]              vld_p1;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  // Step index of the last beat (row NUM_ROWS-1 finishing); modular add
  // keeps this correct for NUM_ROWS == 1 as well.
  assign t_last = {1'b0, len_q} + T_W'(NUM_ROWS - 2);

  // A row is active while the wavefront lies inside its len-beat window.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      active[i] = (t_q >= T_W'(i)) && ((t_q - T_W'(i)) < {1'b0, len_q});
    end
  end

  // Empty flags of rows outside their window are ignored.
  assign stall      = (state == RUN) && |(active & bus.fifo_empty);
  assign final_beat = (state == RUN) && !stall && !bus.abort && (t_q == t_last);
  assign accept     = (state == IDLE) && bus.start && (bus.tile_len != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the pop, busy and done decodes. Pops are gated by
  // reset, so a tile dropped by reset pops nothing in the reset cycle.
  always_comb begin
    state_nxt = state;
    pop       = '0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.tile_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (rst_n && !bus.abort && !stall) begin
          pop = active;
        end
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (final_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Tile length, wavefront position and per-tile stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q       <= '0;
      len_q     <= '0;
      stall_cnt <= '0;
    end else if (accept) begin
      t_q       <= '0;
      len_q     <= bus.tile_len;
      stall_cnt <= '0;
    end else if (state == RUN) begin
      if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end else if (!bus.abort) begin
        t_q <= t_q + T_W'(1);
      end
    end
  end

  // ---- stage p1: popped heads registered toward the accumulator ----
  // Lanes that are not valid carry zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= '0;
      acc_data_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      for (int i = 0; i < NUM_ROWS; i++) begin
        acc_data_p1[i] <= pop[i] ? bus.fifo_data[i] : '0;
      end
    end
  end

  assign bus.fifo_pop     = pop;
  assign bus.acc_in       = acc_data_p1;
  assign bus.acc_valid    = vld_p1;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_acc_skew_scheduler.sv
// Bench for acc_skew_scheduler. Each row has a behavioural FIFO, built from a
// queue. A tile-level reference model runs beside it: it counts wavefront
// steps and derives each row's window from tile_len. The bench covers
// directed table vectors, hand-written corner sequences and randomised tiles.
module tb_acc_skew_scheduler;

  localparam int N    = 4;
  localparam int LW   = 16;
  localparam int LENW = 12;
  localparam int SW   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_skew_scheduler_if #(.NUM_ROWS(N), .LANE_W(LW), .LEN_W(LENW), .STALL_W(SW)) bus();

  acc_skew_scheduler #(.NUM_ROWS(N), .LANE_W(LW), .LEN_W(LENW), .STALL_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  logic [LW-1:0] fq [N][$];

  // reference model state
  bit            m_run;
  bit            m_donep;
  int            m_step;
  int            m_len;
  int            m_stalls;
  logic [N-1:0]  m_vld;
  logic [LW-1:0] m_dat [N];

  // snapshot of DUT outputs at the last sample point
  logic [N-1:0]  s_pop;
  logic [N-1:0]  s_vld;
  logic          s_done;
  logic          s_busy;
  logic [SW-1:0] s_stall;
  logic [LW-1:0] s_acc [N];

  typedef struct {
    bit           refill;
    bit           start;
    int           len;
    bit           abort;
    logic [N-1:0] frc;
    logic [N-1:0] pop;
    logic [N-1:0] vld;
    bit           done;
    bit           busy;
    int           stall;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifo(input logic [N-1:0] frc);
    for (int r = 0; r < N; r++) begin
      bus.fifo_empty[r] = (fq[r].size() == 0) || frc[r];
      bus.fifo_data[r]  = (fq[r].size() != 0) ? fq[r][0] : '0;
    end
  endtask

  task automatic clear_fifos();
    for (int r = 0; r < N; r++) fq[r].delete();
  endtask

  task automatic fill_fifos(input int words);
    for (int r = 0; r < N; r++)
      for (int w = 0; w < words; w++) fq[r].push_back(LW'($urandom));
  endtask

  task automatic model_reset();
    m_run = 0; m_donep = 0; m_step = 0; m_len = 0; m_stalls = 0; m_vld = '0;
    for (int r = 0; r < N; r++) m_dat[r] = '0;
  endtask

  // One clock: drive at negedge, sample and compare, advance model, pop FIFOs.
  task automatic step(input bit rstn_i, input bit st, input int ln, input bit ab,
                      input logic [N-1:0] frc);
    logic [N-1:0] need;
    logic [N-1:0] pops;
    bit           stl;
    @(negedge clk);
    rst_n        = rstn_i;
    bus.start    = st;
    bus.abort    = ab;
    bus.tile_len = LENW'(ln);
    drive_fifo(frc);
    #1;
    s_pop = bus.fifo_pop; s_vld = bus.acc_valid; s_done = bus.done;
    s_busy = bus.busy; s_stall = bus.stall_cycles;
    for (int r = 0; r < N; r++) s_acc[r] = bus.acc_in[r];
    need = '0;
    for (int r = 0; r < N; r++)
      if (m_run && (m_step >= r) && (m_step - r < m_len)) need[r] = 1'b1;
    stl  = |(need & bus.fifo_empty);
    pops = (m_run && rstn_i && !ab && !stl) ? need : '0;
    if (chk_en) begin
      chk("fifo_pop", s_pop, pops);
      chk("pop_on_empty", s_pop & bus.fifo_empty, '0);
      chk("acc_valid", s_vld, m_vld);
      for (int r = 0; r < N; r++) chk($sformatf("acc_in[%0d]", r), s_acc[r], m_dat[r]);
      chk("busy", s_busy, m_run || m_donep);
      chk("done", s_done, m_donep);
      chk("stall_cycles", s_stall, m_stalls);
    end
    for (int r = 0; r < N; r++) m_dat[r] = pops[r] ? fq[r][0] : '0;
    m_vld = pops;
    if (!rstn_i) begin
      model_reset();
    end else if (m_donep) begin
      m_donep = 0;
    end else if (m_run) begin
      if (stl && m_stalls < (1 << SW) - 1) m_stalls++;
      if (ab) begin
        m_run = 0;
      end else if (!stl) begin
        m_step++;
        if (m_step == m_len + N - 1) begin
          m_run = 0;
          m_donep = 1;
        end
      end
    end else if (st) begin
      if (ln != 0) begin
        m_run = 1; m_step = 0; m_len = ln; m_stalls = 0;
      end else begin
        m_donep = 1;
      end
    end
    @(posedge clk);
    for (int r = 0; r < N; r++)
      if (s_pop[r] && fq[r].size() > 0) void'(fq[r].pop_front());
    cyc++;
  endtask

  task automatic addv(input bit rf, input bit st, input int ln, input logic [N-1:0] frc,
                      input logic [N-1:0] pop, input logic [N-1:0] vld,
                      input bit dn, input bit bz, input int sc);
    vec_t v;
    v.refill = rf; v.start = st; v.len = ln; v.abort = 1'b0; v.frc = frc;
    v.pop = pop; v.vld = vld; v.done = dn; v.busy = bz; v.stall = sc;
    tbl.push_back(v);
  endtask

  initial begin
    int runc;
    int donec;
    int budget;
    bus.start = 0; bus.abort = 0; bus.tile_len = '0;
    bus.fifo_data = '0; bus.fifo_empty = '1;
    model_reset();

    // Directed vectors: plain tile, stall at t=3 on row 2, inactive row 3 empty.
    addv(1,1,3,4'b0000, 4'b0000,4'b0000,0,0,0);
    addv(0,0,0,4'b0000, 4'b0001,4'b0000,0,1,0);
    addv(0,0,0,4'b0000, 4'b0011,4'b0001,0,1,0);
    addv(0,0,0,4'b0000, 4'b0111,4'b0011,0,1,0);
    addv(0,0,0,4'b0000, 4'b1110,4'b0111,0,1,0);
    addv(0,0,0,4'b0000, 4'b1100,4'b1110,0,1,0);
    addv(0,0,0,4'b0000, 4'b1000,4'b1100,0,1,0);
    addv(0,0,0,4'b0000, 4'b0000,4'b1000,1,1,0);
    addv(0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0);
    addv(1,1,3,4'b0000, 4'b0000,4'b0000,0,0,0);
    addv(0,0,0,4'b0000, 4'b0001,4'b0000,0,1,0);
    addv(0,0,0,4'b0000, 4'b0011,4'b0001,0,1,0);
    addv(0,0,0,4'b0000, 4'b0111,4'b0011,0,1,0);
    addv(0,0,0,4'b0100, 4'b0000,4'b0111,0,1,0);
    addv(0,0,0,4'b0100, 4'b0000,4'b0000,0,1,1);
    addv(0,0,0,4'b0000, 4'b1110,4'b0000,0,1,2);
    addv(0,0,0,4'b0000, 4'b1100,4'b1110,0,1,2);
    addv(0,0,0,4'b0000, 4'b1000,4'b1100,0,1,2);
    addv(0,0,0,4'b0000, 4'b0000,4'b1000,1,1,2);
    addv(0,0,0,4'b0000, 4'b0000,4'b0000,0,0,2);
    addv(1,1,3,4'b0000, 4'b0000,4'b0000,0,0,2);
    addv(0,0,0,4'b1000, 4'b0001,4'b0000,0,1,0);
    addv(0,0,0,4'b1000, 4'b0011,4'b0001,0,1,0);
    addv(0,0,0,4'b1000, 4'b0111,4'b0011,0,1,0);
    addv(0,0,0,4'b0000, 4'b1110,4'b0111,0,1,0);
    addv(0,0,0,4'b0000, 4'b1100,4'b1110,0,1,0);
    addv(0,0,0,4'b0000, 4'b1000,4'b1100,0,1,0);
    addv(0,0,0,4'b0000, 4'b0000,4'b1000,1,1,0);
    addv(0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0);

    // Reset, then the reset state.
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk_en = 1'b1;
    step(1, 0, 0, 0, '0);
    chk("reset_valid", s_vld, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_done", s_done, 0);
    chk("reset_stall", s_stall, 0);
    chk("reset_pop", s_pop, 0);

    foreach (tbl[k]) begin
      if (tbl[k].refill) begin
        clear_fifos();
        fill_fifos(3);
      end
      step(1, tbl[k].start, tbl[k].len, tbl[k].abort, tbl[k].frc);
      chk("tbl_pop", s_pop, tbl[k].pop);
      chk("tbl_valid", s_vld, tbl[k].vld);
      chk("tbl_done", s_done, tbl[k].done);
      chk("tbl_busy", s_busy, tbl[k].busy);
      chk("tbl_stall", s_stall, tbl[k].stall);
    end

    // Zero-length tile: done one cycle later, nothing popped or valid.
    clear_fifos();
    fill_fifos(3);
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    chk("zero_done", s_done, 1);
    chk("zero_pop", s_pop, 0);
    chk("zero_valid", s_vld, 0);
    step(1, 0, 0, 0, '0);
    chk("zero_done_gone", s_done, 0);
    chk("zero_valid2", s_vld, 0);

    // Abort at t=2, then a clean tile of length 1.
    step(1, 1, 3, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 1, '0);
    chk("abort_pop", s_pop, 0);
    donec = 0;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, '0);
      if (k == 0) chk("abort_idle", s_busy, 0);
      if (s_done) donec++;
    end
    chk("abort_no_done", donec, 0);
    clear_fifos();
    fill_fifos(1);
    step(1, 1, 1, 0, '0);
    runc = 0;
    donec = 0;
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 0, 0, '0);
      if (s_busy && !s_done) runc++;
      if (s_done) donec++;
    end
    chk("len1_run_cycles", runc, N);
    chk("len1_done_count", donec, 1);

    // Reset at t=4 of a running tile, with an ignored start at t=1.
    clear_fifos();
    fill_fifos(3);
    step(1, 1, 3, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 1, 5, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("rst_mid_pop", s_pop, 0);
    chk("rst_mid_done", s_done, 0);
    step(1, 0, 0, 0, '0);
    chk("rst_after_valid", s_vld, 0);
    chk("rst_after_busy", s_busy, 0);
    chk("rst_after_done", s_done, 0);
    chk("rst_after_stall", s_stall, 0);
    chk("rst_after_pop", s_pop, 0);
    for (int r = 0; r < N; r++) chk("rst_after_acc", s_acc[r], 0);

    // Randomised tiles with random empties, spurious starts and rare aborts.
    for (int tile = 0; tile < 40; tile++) begin
      int ln;
      ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      clear_fifos();
      fill_fifos(ln);
      step(1, 1, ln, 0, '0);
      budget = 0;
      while ((m_run || m_donep) && budget < 200) begin
        logic [N-1:0] frc;
        for (int r = 0; r < N; r++) frc[r] = ($urandom_range(0, 3) == 0);
        step(1, $urandom_range(0, 4) == 0, int'($urandom_range(0, 6)),
             $urandom_range(0, 39) == 0, frc);
        budget++;
      end
      if (budget >= 200) begin
        checks++;
        errors++;
        $display("FAIL tile_timeout tile=%0d got=%0d want<200", tile, budget);
      end
      step(1, 0, 0, 0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
